// File: rtl/div_pkg.sv
// ---------------------------------------------------------------------------
// div_pkg
// Shared definitions for the sequential signed divider:
//   divState_t    - control FSM states (IDLE, RUN, DONE)
//   DEFAULT_WIDTH - default operand/result width
//   MOST_NEG      - most-negative two's-complement value at DEFAULT_WIDTH
//   CNT_W         - iteration counter width at DEFAULT_WIDTH
//   cntWidth()    - iteration counter width for an arbitrary WIDTH
// ---------------------------------------------------------------------------
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } divState_t;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic [DEFAULT_WIDTH-1:0] MOST_NEG = {1'b1, {(DEFAULT_WIDTH-1){1'b0}}};

  // Counter must hold 0..w-1; guard keeps the width legal for tiny w.
  function automatic int cntWidth(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

  localparam int CNT_W = cntWidth(DEFAULT_WIDTH);

endpackage

// File: rtl/div_sub_step.sv
// ---------------------------------------------------------------------------
// div_sub_step
// One combinational restoring-division trial subtraction.
// Ports:
//   partial  [WIDTH:0]   in  shifted partial remainder for this step
//   divisor  [WIDTH-1:0] in  divisor magnitude (unsigned)
//   diff     [WIDTH:0]   out partial - divisor (valid when nonneg=1)
//   nonneg   1           out 1 when partial >= divisor
// ---------------------------------------------------------------------------
module div_sub_step
  import div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH:0]   partial,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   diff,
  output logic             nonneg
);

  // One extra guard bit catches the borrow: it is set exactly when the
  // trial subtraction would go negative.
  logic [WIDTH+1:0] fullDiff;

  assign fullDiff = {1'b0, partial} - {2'b00, divisor};
  assign diff     = fullDiff[WIDTH:0];
  assign nonneg   = ~fullDiff[WIDTH+1];

endmodule

// File: rtl/seq_divider.sv
// ---------------------------------------------------------------------------
// seq_divider
// Sequential signed divider, one restoring step per clock.
// Quotient truncates toward zero; remainder takes the dividend's sign.
// Ports:
//   clock           in   rising-edge clock
//   reset_n         in   asynchronous active-low reset
//   ctrl_DIV        in   start pulse (also aborts/restarts a running op)
//   data_operandA   in   signed dividend, sampled with ctrl_DIV
//   data_operandB   in   signed divisor, sampled with ctrl_DIV
//   data_result     out  signed quotient (held until next result)
//   data_remainder  out  signed remainder (held until next result)
//   data_exception  out  divide-by-zero or overflow flag for the result
//   data_resultRDY  out  one-cycle pulse when a new result is presented
// ---------------------------------------------------------------------------
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic [WIDTH-1:0] data_remainder,
  output logic             data_exception,
  output logic             data_resultRDY
);

  localparam int CW = cntWidth(WIDTH);
  localparam logic [WIDTH-1:0] MOST_NEG_W = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CW-1:0]    LAST_STEP  = CW'(WIDTH - 1);

  divState_t      state;
  logic [CW-1:0]  stepCount;
  logic [WIDTH:0] remReg;
  logic [WIDTH-1:0] quoReg;
  logic [WIDTH-1:0] divisorMag;
  logic           negQuot;
  logic           negRem;
  logic           excPending;
  logic           divZero;

  // Operand decode for the start cycle. The magnitude of the most-negative
  // value is the unsigned pattern 100..0, which the datapath treats as an
  // ordinary unsigned number, so no special casing is needed there.
  logic           signA;
  logic           signB;
  logic [WIDTH-1:0] magA;
  logic [WIDTH-1:0] magB;
  logic           startDivZero;
  logic           startOverflow;

  assign signA         = data_operandA[WIDTH-1];
  assign signB         = data_operandB[WIDTH-1];
  assign magA          = signA ? (WIDTH'(0) - data_operandA) : data_operandA;
  assign magB          = signB ? (WIDTH'(0) - data_operandB) : data_operandB;
  assign startDivZero  = (data_operandB == '0);
  assign startOverflow = (data_operandA == MOST_NEG_W) && (data_operandB == '1);

  // Shift the next dividend bit into the partial remainder and try the
  // subtraction. The remainder stays below the divisor between steps, so
  // its top bit is always zero and only the low WIDTH bits shift up.
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trialDiff;
  logic           trialNonNeg;
  logic           unusedRemMsb;

  assign shifted      = {remReg[WIDTH-1:0], quoReg[WIDTH-1]};
  assign unusedRemMsb = remReg[WIDTH];

  div_sub_step #(
    .WIDTH (WIDTH)
  ) u_sub_step (
    .partial (shifted),
    .divisor (divisorMag),
    .diff    (trialDiff),
    .nonneg  (trialNonNeg)
  );

  // Control FSM with registered outputs. A start pulse wins in every state,
  // which is how an in-flight operation is aborted and restarted. The quotient
  // register doubles as the dividend shifter: dividend bits leave at the top
  // while quotient bits enter at the bottom. For a zero divisor the raw
  // dividend is parked there instead so DONE can present it as the remainder.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      stepCount      <= '0;
      remReg         <= '0;
      quoReg         <= '0;
      divisorMag     <= '0;
      negQuot        <= 1'b0;
      negRem         <= 1'b0;
      excPending     <= 1'b0;
      divZero        <= 1'b0;
      data_result    <= '0;
      data_remainder <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (ctrl_DIV) begin
        stepCount  <= '0;
        remReg     <= '0;
        divisorMag <= magB;
        negQuot    <= signA ^ signB;
        negRem     <= signA;
        excPending <= startDivZero | startOverflow;
        divZero    <= startDivZero;
        if (startDivZero) begin
          quoReg <= data_operandA;
          state  <= DONE;
        end else begin
          quoReg <= magA;
          state  <= RUN;
        end
      end else begin
        case (state)
          RUN: begin
            remReg    <= trialNonNeg ? trialDiff : shifted;
            quoReg    <= {quoReg[WIDTH-2:0], trialNonNeg};
            stepCount <= stepCount + CW'(1);
            if (stepCount == LAST_STEP) begin
              state <= DONE;
            end
          end
          DONE: begin
            if (divZero) begin
              data_result    <= '0;
              data_remainder <= quoReg;
            end else begin
              data_result    <= negQuot ? (WIDTH'(0) - quoReg) : quoReg;
              data_remainder <= negRem ? (WIDTH'(0) - remReg[WIDTH-1:0])
                                       : remReg[WIDTH-1:0];
            end
            data_exception <= excPending;
            data_resultRDY <= 1'b1;
            state          <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// ---------------------------------------------------------------------------
// tb_seq_divider
// Scoreboard bench for seq_divider: each start pushes the expected result and
// the edge on which it must appear; the monitor pops and compares on RDY and
// checks that outputs hold steady in every other cycle.
// ---------------------------------------------------------------------------
module tb_seq_divider;
  import div_pkg::*;

  localparam int W = DEFAULT_WIDTH;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         ctrl_DIV = 1'b0;
  logic [W-1:0] data_operandA = '0;
  logic [W-1:0] data_operandB = '0;
  logic [W-1:0] data_result;
  logic [W-1:0] data_remainder;
  logic         data_exception;
  logic         data_resultRDY;

  seq_divider #(
    .WIDTH (W)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_remainder (data_remainder),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [W-1:0] res;
    logic [W-1:0] rem;
    logic         exc;
    int           dueEdge;
  } expect_t;

  expect_t      sbQ[$];
  expect_t      monE;
  int           checkCount = 0;
  int           failCount = 0;
  int           edgeCount = 0;
  logic [W-1:0] heldRes = '0;
  logic [W-1:0] heldRem = '0;
  logic         heldExc = 1'b0;

  int dirA [10] = '{-100, 100, 5, int'(MOST_NEG), int'(MOST_NEG),
                    7, -7, 32'h7fff_ffff, int'(MOST_NEG), -1};
  int dirB [10] = '{7, -7, 0, -1, 1, -100, -2, -1, 7, 0};

  // Count rising edges so result latency can be checked against start edge.
  always @(posedge clock) edgeCount <= edgeCount + 1;

  task automatic checkOutput(input string tag, input logic [W-1:0] actual,
                             input logic [W-1:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Reference model built on the language's own signed division, with the
  // two exceptional cases handled first.
  function automatic expect_t model(input logic signed [W-1:0] a,
                                    input logic signed [W-1:0] b,
                                    input int startEdge);
    expect_t e;
    if (b == 0) begin
      e.res = '0;
      e.rem = a;
      e.exc = 1'b1;
      e.dueEdge = startEdge + 1;
    end else if ((a == MOST_NEG) && (b == -1)) begin
      e.res = MOST_NEG;
      e.rem = '0;
      e.exc = 1'b1;
      e.dueEdge = startEdge + W + 1;
    end else begin
      e.res = a / b;
      e.rem = a % b;
      e.exc = 1'b0;
      e.dueEdge = startEdge + W + 1;
    end
    return e;
  endfunction

  // Called at a falling edge; operands are sampled on the next rising edge.
  // Any pending expectation is dropped because a new start aborts it.
  task automatic applyStimulus(input logic signed [W-1:0] a,
                               input logic signed [W-1:0] b);
    expect_t e;
    e = model(a, b, edgeCount + 1);
    sbQ.delete();
    sbQ.push_back(e);
    ctrl_DIV      = 1'b1;
    data_operandA = a;
    data_operandB = b;
    @(negedge clock);
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  task automatic waitIdle();
    for (int i = 0; i < 100 && sbQ.size() != 0; i++) @(negedge clock);
    if (sbQ.size() != 0) begin
      checkOutput("timeout", W'(sbQ.size()), '0);
      sbQ.delete();
    end
  endtask

  // Monitor samples 1 time unit after each rising edge.
  always @(posedge clock) begin
    #1;
    if (reset_n) begin
      if (data_resultRDY) begin
        if (sbQ.size() == 0) begin
          checkOutput("unexpectedRdy", W'(1), W'(0));
        end else begin
          monE = sbQ.pop_front();
          checkOutput("latency", W'(edgeCount), W'(monE.dueEdge));
          checkOutput("result", data_result, monE.res);
          checkOutput("remainder", data_remainder, monE.rem);
          checkOutput("exception", W'(data_exception), W'(monE.exc));
          heldRes = monE.res;
          heldRem = monE.rem;
          heldExc = monE.exc;
        end
      end else begin
        checkOutput("holdResult", data_result, heldRes);
        checkOutput("holdRemainder", data_remainder, heldRem);
        checkOutput("holdException", W'(data_exception), W'(heldExc));
      end
    end
  end

  initial begin
    #12;
    checkOutput("resetResult", data_result, '0);
    checkOutput("resetRemainder", data_remainder, '0);
    checkOutput("resetException", W'(data_exception), '0);
    checkOutput("resetRdy", W'(data_resultRDY), '0);

    // First start on the first edge after reset release.
    @(negedge clock);
    reset_n = 1'b1;
    applyStimulus(100, 7);
    waitIdle();

    $display("[TB] directed cases");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(dirA[i], dirB[i]);
      waitIdle();
    end

    $display("[TB] random cases");
    for (int i = 0; i < 6; i++) begin
      logic signed [W-1:0] ra;
      logic signed [W-1:0] rb;
      ra = $urandom;
      rb = (i % 2 == 0) ? W'($urandom) : (W'($urandom_range(0, 200)) - W'(100));
      applyStimulus(ra, rb);
      waitIdle();
    end

    $display("[TB] abort and restart");
    applyStimulus(100, 7);
    repeat (9) @(negedge clock);
    applyStimulus(45, 9);
    waitIdle();

    $display("[TB] reset mid-operation");
    applyStimulus(-100, 7);
    waitIdle();
    applyStimulus(100, 7);
    repeat (14) @(negedge clock);
    reset_n = 1'b0;
    sbQ.delete();
    heldRes = '0;
    heldRem = '0;
    heldExc = 1'b0;
    #1;
    checkOutput("midResetResult", data_result, '0);
    checkOutput("midResetRemainder", data_remainder, '0);
    checkOutput("midResetException", W'(data_exception), '0);
    checkOutput("midResetRdy", W'(data_resultRDY), '0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (40) @(negedge clock);

    applyStimulus(-45, 9);
    waitIdle();
    repeat (2) @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits (even, >=4).
REQ-002 SHALL have port clock  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port ctrl_DIV  input  1  start pulse; sampled each rising edge.
REQ-005 SHALL have port data_operandA  input  WIDTH  signed dividend; sampled only when ctrl_DIV=1.
REQ-006 SHALL have port data_operandB  input  WIDTH  signed divisor; sampled only when ctrl_DIV=1.
REQ-007 SHALL have port data_result  output  WIDTH  signed quotient.
REQ-008 SHALL have port data_remainder  output  WIDTH  signed remainder.
REQ-009 SHALL have port data_exception  output  1  divide-by-zero or overflow flag for the current result.
REQ-010 SHALL have port data_resultRDY  output  1  one-cycle pulse marking a new valid result.

Function
REQ-011 SHALL implement signed division, quotient truncated toward zero, remainder sign equal to dividend sign, |remainder| < |divisor|.
REQ-012 SHALL use states IDLE, RUN, DONE; reset enters IDLE.
REQ-013 IDLE: ctrl_DIV=1 -> capture |A|, |B|, result signs, clear iteration counter, go RUN (or DONE directly per REQ-016/017).
REQ-014 RUN: one restoring shift-subtract step per cycle, exactly WIDTH steps; counter counts 0..WIDTH-1; after step WIDTH-1 go DONE.
REQ-015 DONE: apply sign correction, update data_result/data_remainder/data_exception, assert data_resultRDY for exactly that cycle, go IDLE.
REQ-016 Latency: ctrl_DIV sampled at edge k -> data_resultRDY high in cycle following edge k+WIDTH+1 (33 cycles for WIDTH=32), normal case.
REQ-017 Divisor zero: skip RUN; DONE in cycle after edge k; data_result=0, data_remainder=A, data_exception=1.
REQ-018 Overflow (A = most-negative, B = -1): full WIDTH-cycle latency; data_result=most-negative value (wrap), data_remainder=0, data_exception=1.
REQ-019 All other cases SHALL give data_exception=0.
REQ-020 ctrl_DIV=1 in RUN or DONE SHALL abort the current operation without a RDY pulse for it and restart with newly sampled operands, latency measured from the new edge.
REQ-021 data_result, data_remainder, data_exception SHALL hold their last values until the next DONE; they SHALL NOT change during RUN.
REQ-022 Magnitude of most-negative dividend SHALL be handled as an unsigned WIDTH-bit value (no overflow in the datapath); partial remainder register SHALL be WIDTH+1 bits.

Reset
REQ-023 reset_n low SHALL immediately force state IDLE, counter 0, data_result=0, data_remainder=0, data_exception=0, data_resultRDY=0.
REQ-024 Reset asserted mid-operation SHALL discard the operation; no RDY pulse after reset release until a new ctrl_DIV.
REQ-025 Reset release SHALL be treated as synchronous to clock by the environment; first ctrl_DIV honoured on the first edge after release.

Structure
REQ-026 Shared package div_pkg SHALL hold: state enum (IDLE, RUN, DONE), default WIDTH constant, most-negative-value constant, counter width = clog2(WIDTH).
REQ-027 Trial subtraction SHALL be one combinational sub-module, div_sub_step: inputs partial remainder (WIDTH+1) and divisor magnitude; outputs difference and a non-negative flag.
REQ-028 Control FSM, counter, sign handling and output registers SHALL live in seq_divider; no other sub-modules.

Verification
REQ-029 A=100, B=7, ctrl_DIV pulse at edge 0 -> RDY only in cycle 33, result=14, remainder=2, exception=0.
REQ-030 A=-100, B=7 -> result=-14, remainder=-2; A=100, B=-7 -> result=-14, remainder=2; both exception=0.
REQ-031 A=5, B=0 -> RDY in cycle 1, result=0, remainder=5, exception=1.
REQ-032 A=0x80000000, B=-1 -> RDY in cycle 33, result=0x80000000, remainder=0, exception=1; A=0x80000000, B=1 -> result=0x80000000, exception=0.
REQ-033 Start 100/7, re-pulse ctrl_DIV with 45/9 at edge 10 -> single RDY in cycle 43, result=5, remainder=0; no RDY in cycle 33.
REQ-034 Start 100/7, drop reset_n at edge 15 -> outputs 0 immediately; after release, no RDY for 40 cycles without new ctrl_DIV.
